mcp_fetch_regs: RTL and testbench
=================================

// Module: mcp_fetch_regs
// PURPOSE
//  Architectural state registers of the multicycle MIPS datapath: PC, instruction register (IR),
//  memory data register (MDR), ALUOut, plus the next-PC mux and memory address mux.
//  Sits between the unified memory and the controller. Consumes pcen/irwrite/iord/pcsrc.
//  Feeds op/funct and the register fields back to the controller and datapath.
//  Also counts fetched instructions and flags misaligned PC writes.
// PARAMETERS
//  WIDTH     32            datapath width (PC, IR, MDR, ALUOut)
//  RESET_PC  32'h0000_0000 PC value on reset; must be word-aligned
//  CNT_W     32            width of the instret fetch counter
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous reset, active-low (0 = in reset)
//  pcen       in   1      PC write enable from controller
//  irwrite    in   1      IR write enable from controller
//  iord       in   1      memory address select: 0 = PC, 1 = ALUOut
//  pcsrc      in   2      next-PC select: 00 aluresult, 01 aluout, 10 jump target, 11 hold
//  aluresult  in   WIDTH  combinational ALU result
//  readdata   in   WIDTH  memory read data
//  adr        out  WIDTH  memory address (combinational)
//  pc         out  WIDTH  current PC register
//  instr      out  WIDTH  IR contents
//  data       out  WIDTH  MDR contents
//  aluout     out  WIDTH  ALUOut register
//  op         out  6      instr[31:26]
//  funct      out  6      instr[5:0]
//  rs, rt, rd out  5      instr[25:21], instr[20:16], instr[15:11]
//  imm        out  16     instr[15:0]
//  instret    out  CNT_W  count of IR loads since reset
//  misalign   out  1      sticky: a non-word-aligned next PC was written
// BEHAVIOUR
//  - Reset (reset=0, async, no clock required): pc=RESET_PC; instr, data, aluout, instret = 0;
//    misalign=0. Register updates resume on the first rising clk after reset returns to 1.
//  - pcnext: pcsrc 00 -> aluresult; 01 -> aluout; 10 -> {pc[31:28], instr[25:0], 2'b00};
//    11 -> pc (hold).
//  - On a clk edge with pcen=1: pc <= {pcnext[WIDTH-1:2], 2'b00}.
//    If pcnext[1:0] != 0, misalign is set and stays 1 until reset. With pcen=0, pc holds.
//  - With irwrite=1: instr <= readdata and instret <= instret+1.
//    instret wraps from all-ones to 0 with no flag.
//  - MDR loads readdata on every edge. ALUOut loads aluresult on every edge. Neither has an enable.
//  - adr = iord ? aluout : pc. It is combinational, with zero latency.
//  - Decoded fields (op, funct, rs, rt, rd, imm) are combinational slices of the registered instr.
//    They change in the cycle after the irwrite edge.
//  - pcen=1 and irwrite=1 on the same edge (fetch):
//    - IR captures readdata addressed by the old pc.
//    - pc takes pcnext.
//    - adr shows the new pc in the following cycle.
//  - Jump target uses the pc and instr values current in that cycle (pc already incremented
//    after fetch). The jump target is always aligned, so it never sets misalign.
//  - 1-cycle latency on every register; no handshake; the controller sequences all enables.
// TESTING
//  1 Reset: hold reset=0 with random inputs toggling -> pc=0, instr=0, instret=0, misalign=0;
//    adr=0 when iord=0.
//  2 Fetch: readdata=32'h8C08_0004, aluresult=4, pcen=irwrite=1, pcsrc=00, one edge
//    -> instr=32'h8C08_0004, op=6'h23, rt=8, imm=4, pc=4, instret=1.
//  3 Branch: aluresult=32'h40 on edge N, then pcsrc=01, pcen=1 on edge N+1 -> pc=32'h40;
//    iord=1 -> adr=32'h40.
//  4 Jump: pc=32'h1000_0004, instr=32'h0800_0010, pcsrc=10, pcen=1 -> pc=32'h1000_0040.
//  5 Misaligned PC: aluresult=32'h0000_0106, pcsrc=00, pcen=1 -> pc=32'h104, misalign=1.
//    misalign stays 1 after further aligned writes.
//  6 Wrap and mid-operation reset: with CNT_W=4, 17 irwrite pulses -> instret=1.
//    Then drop reset=0 between clock edges -> all registers clear immediately (async).

Source files
------------

// File: rtl/mcp_fetch_regs.sv
// mcp_fetch_regs
//   Architectural state registers for the multicycle MIPS datapath: PC,
//   instruction register (IR), memory data register (MDR) and ALUOut, together
//   with the next-PC mux and the memory address mux. It also counts IR loads
//   (instret) and keeps a sticky flag for misaligned PC writes.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous reset, active-low (0 = in reset)
//   pcen       PC write enable
//   irwrite    IR write enable (also increments instret)
//   iord       memory address select: 0 = PC, 1 = ALUOut
//   pcsrc      next-PC select: 00 aluresult, 01 aluout, 10 jump target, 11 hold
//   aluresult  combinational ALU result
//   readdata   memory read data
//   adr        memory address (combinational)
//   pc, instr, data, aluout   architectural registers
//   op, funct, rs, rt, rd, imm  combinational slices of the IR
//   instret    IR load count since reset (wraps silently)
//   misalign   sticky: a PC write with non-zero low two bits happened
module mcp_fetch_regs #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pcen,
  input  logic             irwrite,
  input  logic             iord,
  input  logic [1:0]       pcsrc,
  input  logic [WIDTH-1:0] aluresult,
  input  logic [WIDTH-1:0] readdata,
  output logic [WIDTH-1:0] adr,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] aluout,
  output logic [5:0]       op,
  output logic [5:0]       funct,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [15:0]      imm,
  output logic [CNT_W-1:0] instret,
  output logic             misalign
);

  logic [WIDTH-1:0] pc_reg;
  logic [WIDTH-1:0] instr_reg;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] aluout_reg;
  logic [CNT_W-1:0] instret_reg;
  logic             misalign_reg;

  logic [WIDTH-1:0] pcnext;
  logic [WIDTH-1:0] jump_target;

  // Jump target keeps the upper nibble of the (already incremented) PC and
  // replaces the rest with the 26-bit word index from the IR; always aligned.
  assign jump_target = {pc_reg[WIDTH-1:28], instr_reg[25:0], 2'b00};

  always_comb begin
    pcnext = pc_reg;
    case (pcsrc)
      2'b00:   pcnext = aluresult;
      2'b01:   pcnext = aluout_reg;
      2'b10:   pcnext = jump_target;
      default: pcnext = pc_reg;
    endcase
  end

  // Architectural registers. The PC always stores a word-aligned value; a
  // misaligned request is truncated and latched in the sticky flag instead.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg       <= {RESET_PC[WIDTH-1:2], 2'b00};
      instr_reg    <= '0;
      data_reg     <= '0;
      aluout_reg   <= '0;
      instret_reg  <= '0;
      misalign_reg <= 1'b0;
    end else begin
      if (pcen) begin
        pc_reg <= {pcnext[WIDTH-1:2], 2'b00};
        if (pcnext[1:0] != 2'b00) begin
          misalign_reg <= 1'b1;
        end
      end
      if (irwrite) begin
        instr_reg   <= readdata;
        instret_reg <= instret_reg + CNT_W'(1);
      end
      // MDR and ALUOut capture every cycle; the controller decides when
      // their contents are meaningful.
      data_reg   <= readdata;
      aluout_reg <= aluresult;
    end
  end

  assign adr      = iord ? aluout_reg : pc_reg;
  assign pc       = pc_reg;
  assign instr    = instr_reg;
  assign data     = data_reg;
  assign aluout   = aluout_reg;
  assign instret  = instret_reg;
  assign misalign = misalign_reg;

  assign op    = instr_reg[31:26];
  assign rs    = instr_reg[25:21];
  assign rt    = instr_reg[20:16];
  assign rd    = instr_reg[15:11];
  assign imm   = instr_reg[15:0];
  assign funct = instr_reg[5:0];

endmodule

// File: tb/tb_mcp_fetch_regs.sv
module tb_mcp_fetch_regs;

  localparam int W  = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          pcen, irwrite, iord;
  logic [1:0]    pcsrc;
  logic [W-1:0]  aluresult, readdata;
  logic [W-1:0]  adr, pc, instr, data, aluout;
  logic [5:0]    op, funct;
  logic [4:0]    rs, rt, rd;
  logic [15:0]   imm;
  logic [CW-1:0] instret;
  logic          misalign;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mcp_fetch_regs #(.WIDTH(W), .RESET_PC(32'h0), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .pcen(pcen), .irwrite(irwrite), .iord(iord),
    .pcsrc(pcsrc), .aluresult(aluresult), .readdata(readdata),
    .adr(adr), .pc(pc), .instr(instr), .data(data), .aluout(aluout),
    .op(op), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
    .instret(instret), .misalign(misalign)
  );

  // Apply an edge: wait for the rising edge, then settle 1 time unit past it.
  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pcen = 0; irwrite = 0; iord = 0; pcsrc = 2'b11;
    aluresult = '0; readdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(posedge clk); #3;
    reset = 0;
    #4;
    reset = 1;
    #1;
  endtask

  task automatic test_reset();
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      pcen = 1'($urandom); irwrite = 1'($urandom); pcsrc = 2'($urandom);
      aluresult = $urandom; readdata = $urandom; iord = 0;
      @(posedge clk); #1;
    end
    n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    n_cmp++; if (instr !== 32'h0) begin n_bad++; $display("FAIL reset_instr got=%h exp=%h", instr, 32'h0); end
    n_cmp++; if (instret !== 4'h0) begin n_bad++; $display("FAIL reset_instret got=%h exp=0", instret); end
    n_cmp++; if (misalign !== 1'b0) begin n_bad++; $display("FAIL reset_misalign got=%b exp=0", misalign); end
    n_cmp++; if (adr !== 32'h0) begin n_bad++; $display("FAIL reset_adr got=%h exp=0", adr); end
    $display("txn reset: pc=%h instr=%h instret=%0d misalign=%b", pc, instr, instret, misalign);
    idle_inputs();
    @(negedge clk);
    reset = 1;
    #1;
  endtask

  task automatic test_fetch();
    readdata = 32'h8C08_0004; aluresult = 32'h4;
    pcen = 1; irwrite = 1; pcsrc = 2'b00; iord = 0;
    edge_step();
    idle_inputs();
    n_cmp++; if (instr !== 32'h8C08_0004) begin n_bad++; $display("FAIL fetch_instr got=%h exp=8c080004", instr); end
    n_cmp++; if (op !== 6'h23) begin n_bad++; $display("FAIL fetch_op got=%h exp=23", op); end
    n_cmp++; if (rt !== 5'd8) begin n_bad++; $display("FAIL fetch_rt got=%0d exp=8", rt); end
    n_cmp++; if (imm !== 16'h4) begin n_bad++; $display("FAIL fetch_imm got=%h exp=4", imm); end
    n_cmp++; if (pc !== 32'h4) begin n_bad++; $display("FAIL fetch_pc got=%h exp=4", pc); end
    n_cmp++; if (instret !== 4'd1) begin n_bad++; $display("FAIL fetch_instret got=%0d exp=1", instret); end
    n_cmp++; if (adr !== 32'h4) begin n_bad++; $display("FAIL fetch_adr got=%h exp=4", adr); end
    $display("txn fetch: instr=%h op=%h rt=%0d imm=%h pc=%h instret=%0d", instr, op, rt, imm, pc, instret);
  endtask

  task automatic test_branch();
    aluresult = 32'h40; pcen = 0; pcsrc = 2'b11;
    edge_step();
    n_cmp++; if (aluout !== 32'h40) begin n_bad++; $display("FAIL branch_aluout got=%h exp=40", aluout); end
    aluresult = 32'h80; pcsrc = 2'b01; pcen = 1;
    edge_step();
    n_cmp++; if (pc !== 32'h40) begin n_bad++; $display("FAIL branch_pc got=%h exp=40", pc); end
    pcen = 0; pcsrc = 2'b11; aluresult = 32'h40;
    edge_step();
    iord = 1; #1;
    n_cmp++; if (adr !== 32'h40) begin n_bad++; $display("FAIL branch_adr_iord1 got=%h exp=40", adr); end
    aluresult = 32'h120;
    edge_step();
    n_cmp++; if (adr !== 32'h120) begin n_bad++; $display("FAIL branch_adr_aluout got=%h exp=120", adr); end
    iord = 0; #1;
    n_cmp++; if (adr !== 32'h40) begin n_bad++; $display("FAIL branch_adr_iord0 got=%h exp=40", adr); end
    $display("txn branch: pc=%h aluout=%h", pc, aluout);
    idle_inputs();
  endtask

  task automatic test_jump();
    aluresult = 32'h1000_0004; readdata = 32'h0800_0010;
    pcsrc = 2'b00; pcen = 1; irwrite = 1;
    edge_step();
    n_cmp++; if (pc !== 32'h1000_0004) begin n_bad++; $display("FAIL jump_setup_pc got=%h exp=10000004", pc); end
    irwrite = 0; pcsrc = 2'b10; pcen = 1; aluresult = 32'h3;
    edge_step();
    n_cmp++; if (pc !== 32'h1000_0040) begin n_bad++; $display("FAIL jump_pc got=%h exp=10000040", pc); end
    n_cmp++; if (misalign !== 1'b0) begin n_bad++; $display("FAIL jump_misalign got=%b exp=0", misalign); end
    pcsrc = 2'b11; pcen = 1;
    edge_step();
    n_cmp++; if (pc !== 32'h1000_0040) begin n_bad++; $display("FAIL hold_pc got=%h exp=10000040", pc); end
    $display("txn jump: pc=%h instr=%h misalign=%b", pc, instr, misalign);
    idle_inputs();
  endtask

  task automatic test_misalign();
    aluresult = 32'h0000_0106; pcsrc = 2'b00; pcen = 0;
    edge_step();
    n_cmp++; if (misalign !== 1'b0) begin n_bad++; $display("FAIL misalign_no_pcen got=%b exp=0", misalign); end
    pcen = 1;
    edge_step();
    n_cmp++; if (pc !== 32'h104) begin n_bad++; $display("FAIL misalign_pc got=%h exp=104", pc); end
    n_cmp++; if (misalign !== 1'b1) begin n_bad++; $display("FAIL misalign_set got=%b exp=1", misalign); end
    aluresult = 32'h200;
    edge_step();
    edge_step();
    n_cmp++; if (pc !== 32'h200) begin n_bad++; $display("FAIL misalign_aligned_pc got=%h exp=200", pc); end
    n_cmp++; if (misalign !== 1'b1) begin n_bad++; $display("FAIL misalign_sticky got=%b exp=1", misalign); end
    $display("txn misalign: pc=%h misalign=%b", pc, misalign);
    idle_inputs();
  endtask

  task automatic test_wrap_reset();
    do_reset();
    aluresult = 32'h8; pcsrc = 2'b00; pcen = 1;
    for (int i = 0; i < 17; i++) begin
      readdata = 32'h1234_0000 + i; irwrite = 1;
      edge_step();
      irwrite = 0;
      edge_step();
    end
    n_cmp++; if (instret !== 4'd1) begin n_bad++; $display("FAIL wrap_instret got=%0d exp=1", instret); end
    $display("txn wrap: instret=%0d instr=%h", instret, instr);
    // pc, aluout, data and instr are all non-zero at this point.
    #2; reset = 0; #1;
    n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL async_pc got=%h exp=0", pc); end
    n_cmp++; if (instr !== 32'h0) begin n_bad++; $display("FAIL async_instr got=%h exp=0", instr); end
    n_cmp++; if (data !== 32'h0) begin n_bad++; $display("FAIL async_data got=%h exp=0", data); end
    n_cmp++; if (aluout !== 32'h0) begin n_bad++; $display("FAIL async_aluout got=%h exp=0", aluout); end
    n_cmp++; if (instret !== 4'd0) begin n_bad++; $display("FAIL async_instret got=%0d exp=0", instret); end
    n_cmp++; if (misalign !== 1'b0) begin n_bad++; $display("FAIL async_misalign got=%b exp=0", misalign); end
    $display("txn async_reset: pc=%h instr=%h instret=%0d", pc, instr, instret);
    idle_inputs();
    @(negedge clk);
    reset = 1;
    #1;
  endtask

  // Randomized run against a behavioural model built from the rules:
  // next PC chosen by pcsrc, stored rounded down to a multiple of 4,
  // IR loads counted modulo 2^CW, MDR/ALUOut capture every cycle.
  task automatic test_random();
    longint unsigned m_pc, m_instr, m_data, m_aluout, m_next;
    int unsigned     m_cnt;
    bit              m_mis;
    do_reset();
    m_pc = 0; m_instr = 0; m_data = 0; m_aluout = 0; m_cnt = 0; m_mis = 0;
    for (int t = 0; t < 60; t++) begin
      pcen = 1'($urandom); irwrite = 1'($urandom); iord = 1'($urandom);
      pcsrc = 2'($urandom);
      aluresult = $urandom; readdata = $urandom;
      if ($urandom_range(0, 3) != 0) aluresult[1:0] = 2'b00;
      #1;
      n_cmp++;
      if (adr !== 32'(iord ? m_aluout : m_pc)) begin
        n_bad++; $display("FAIL rand_adr t=%0d got=%h exp=%h", t, adr, 32'(iord ? m_aluout : m_pc));
      end
      case (pcsrc)
        2'd0: m_next = aluresult;
        2'd1: m_next = m_aluout;
        2'd2: m_next = (m_pc / 64'h1000_0000) * 64'h1000_0000 + (m_instr % 64'h400_0000) * 4;
        default: m_next = m_pc;
      endcase
      if (pcen) begin
        if (m_next % 4 != 0) m_mis = 1;
        m_pc = m_next - (m_next % 4);
      end
      if (irwrite) begin
        m_instr = readdata;
        m_cnt = (m_cnt + 1) % 16;
      end
      m_data = readdata;
      m_aluout = aluresult;
      edge_step();
      n_cmp++; if (pc !== 32'(m_pc)) begin n_bad++; $display("FAIL rand_pc t=%0d got=%h exp=%h", t, pc, 32'(m_pc)); end
      n_cmp++; if (instr !== 32'(m_instr)) begin n_bad++; $display("FAIL rand_instr t=%0d got=%h exp=%h", t, instr, 32'(m_instr)); end
      n_cmp++; if (data !== 32'(m_data)) begin n_bad++; $display("FAIL rand_data t=%0d got=%h exp=%h", t, data, 32'(m_data)); end
      n_cmp++; if (aluout !== 32'(m_aluout)) begin n_bad++; $display("FAIL rand_aluout t=%0d got=%h exp=%h", t, aluout, 32'(m_aluout)); end
      n_cmp++; if (instret !== 4'(m_cnt)) begin n_bad++; $display("FAIL rand_instret t=%0d got=%0d exp=%0d", t, instret, m_cnt); end
      n_cmp++; if (misalign !== m_mis) begin n_bad++; $display("FAIL rand_misalign t=%0d got=%b exp=%b", t, misalign, m_mis); end
      n_cmp++;
      if ({op, rs, rt, rd, funct} !== {6'(m_instr / 64'h400_0000), 5'((m_instr / 64'h20_0000) % 32),
                                       5'((m_instr / 64'h1_0000) % 32), 5'((m_instr / 64'h800) % 32),
                                       6'(m_instr % 64)}) begin
        n_bad++; $display("FAIL rand_fields t=%0d op=%h rs=%0d rt=%0d rd=%0d funct=%h instr_exp=%h",
                          t, op, rs, rt, rd, funct, 32'(m_instr));
      end
      n_cmp++; if (imm !== 16'(m_instr % 65536)) begin n_bad++; $display("FAIL rand_imm t=%0d got=%h exp=%h", t, imm, 16'(m_instr % 65536)); end
      $display("txn rand %0d: pcsrc=%0d pcen=%b irw=%b pc=%h instr=%h instret=%0d mis=%b",
               t, pcsrc, pcen, irwrite, pc, instr, instret, misalign);
    end
    idle_inputs();
  endtask

  initial begin
    reset = 0;
    idle_inputs();
    test_reset();
    test_fetch();
    test_branch();
    test_jump();
    test_misalign();
    test_wrap_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
